// File: rtl/result_tx_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// result_tx_sequencer_pkg
// Shared definitions for the result transmit sequencer:
//   - FSM state encoding (3-bit)
//   - default frame header byte
//   - bytes-per-neuron and frame-length helper functions
// ---------------------------------------------------------------------------
package result_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CAPTURE   = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    // Bytes needed to carry one neuron output of width dw.
    function automatic int calc_bpw(input int dw);
        return (dw + 7) / 8;
    endfunction

    // Total bytes in one frame: optional header, payload, optional checksum.
    function automatic int calc_frame_len(input int nn, input int dw,
                                          input bit hdr, input bit cks);
        return int'(hdr) + nn * calc_bpw(dw) + int'(cks);
    endfunction

endpackage

// File: rtl/result_tx_sequencer_snapshot.sv
// ---------------------------------------------------------------------------
// result_snapshot
// Capture register for all neuron outputs, each sign-extended to a whole
// number of bytes, plus a combinational byte-select mux.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   capture_i       load neuron_out_i into the snapshot this cycle
//   neuron_out_i    flat signed neuron outputs, neuron 0 in the LSBs
//   byte_idx_i      payload byte index (neuron-major, little-endian)
//   byte_o          selected snapshot byte
// ---------------------------------------------------------------------------
module result_snapshot
    import result_tx_sequencer_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int IDX_W       = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              capture_i,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out_i,
    input  logic [IDX_W-1:0]                  byte_idx_i,
    output logic [7:0]                        byte_o
);

    localparam int BPW = calc_bpw(DATA_WIDTH);
    localparam int NB  = NUM_NEURONS * BPW;
    localparam int W8  = BPW * 8;

    logic [NB*8-1:0] snap_q;
    logic [NB*8-1:0] snap_d;

    // Signed size cast replicates each neuron's MSB into the padding bits.
    always_comb begin
        snap_d = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            snap_d[i*W8 +: W8] = W8'($signed(neuron_out_i[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else if (capture_i) begin
            snap_q <= snap_d;
        end
    end

    // Explicit loop mux keeps every select in range for any NB.
    always_comb begin
        byte_o = 8'h00;
        for (int j = 0; j < NB; j++) begin
            if (byte_idx_i == IDX_W'(j)) begin
                byte_o = snap_q[j*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/result_tx_sequencer.sv
// ---------------------------------------------------------------------------
// result_tx_sequencer
// After each accepted compute-mode byte, waits SETTLE_CYCLES, snapshots all
// neuron outputs and streams them to a UART transmitter as a frame:
//   [HEADER_BYTE] n0.b0 .. n0.b(BPW-1) .. n(N-1).b(BPW-1) [XOR checksum]
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   result_valid   one-cycle trigger pulse
//   neuron_out     flat signed neuron outputs, neuron 0 in the LSBs
//   tx_active      transmitter busy; holds the next byte back
//   tx_done        one-cycle pulse, current byte fully shifted out
//   clear_overrun  clears the sticky overrun flag
//   tx_start       one-cycle request to send tx_data
//   tx_data        byte to send, stable until its tx_done
//   busy           frame in progress
//   overrun        sticky, a trigger arrived while busy and was dropped
//   frame_count    completed frames, wrapping
// Handshake: in LOAD, tx_start is raised for one cycle only while tx_active
// is low; tx_data is valid in that cycle and held until tx_done, which is
// honoured only in WAIT_DONE.
// ---------------------------------------------------------------------------
module result_tx_sequencer
    import result_tx_sequencer_pkg::*;
#(
    parameter int         NUM_NEURONS   = 4,
    parameter int         DATA_WIDTH    = 8,
    parameter int         SETTLE_CYCLES = 2,
    parameter bit         HEADER_EN     = 1'b1,
    parameter logic [7:0] HEADER_BYTE   = DEFAULT_HEADER_BYTE,
    parameter bit         CHECKSUM_EN   = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              result_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic                              tx_active,
    input  logic                              tx_done,
    input  logic                              clear_overrun,
    output logic                              tx_start,
    output logic [7:0]                        tx_data,
    output logic                              busy,
    output logic                              overrun,
    output logic [15:0]                       frame_count
);

    localparam int         NB        = NUM_NEURONS * calc_bpw(DATA_WIDTH);
    localparam int         IDX_W     = (NB > 1) ? $clog2(NB) : 1;
    localparam int         FRAME_LEN = calc_frame_len(NUM_NEURONS, DATA_WIDTH,
                                                      HEADER_EN, CHECKSUM_EN);
    localparam logic [7:0] LAST_IDX  = 8'(FRAME_LEN - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  fi_q, fi_d;        // byte index within the frame
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  txd_q, txd_d;
    logic        ovr_q, ovr_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        capture;
    logic [7:0]  snap_byte;
    logic [7:0]  cur_byte;
    logic [7:0]  data_idx;

    // Payload index skips the header slot when one is present.
    assign data_idx = fi_q - 8'(HEADER_EN);

    result_snapshot #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .IDX_W       (IDX_W)
    ) u_snapshot (
        .clk          (clk),
        .reset        (reset),
        .capture_i    (capture),
        .neuron_out_i (neuron_out),
        .byte_idx_i   (IDX_W'(data_idx)),
        .byte_o       (snap_byte)
    );

    always_comb begin
        cur_byte = snap_byte;
        if (HEADER_EN && fi_q == 8'd0) begin
            cur_byte = HEADER_BYTE;
        end else if (CHECKSUM_EN && fi_q == LAST_IDX) begin
            cur_byte = csum_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fi_d     = fi_q;
        csum_d   = csum_q;
        txd_d    = txd_q;
        fcnt_d   = fcnt_q;
        capture  = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (result_valid) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'(SETTLE_CYCLES)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                fi_d    = 8'd0;
                csum_d  = 8'd0;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!tx_active) begin
                    tx_start = 1'b1;
                    txd_d    = cur_byte;
                    csum_d   = csum_q ^ cur_byte;
                    state_d  = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (fi_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        fcnt_d  = fcnt_q + 16'd1;
                    end else begin
                        fi_d    = fi_q + 8'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A dropped trigger takes priority over a simultaneous clear.
    always_comb begin
        ovr_d = ovr_q;
        if (result_valid && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end else if (clear_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            fi_q    <= 8'd0;
            csum_q  <= 8'd0;
            txd_q   <= 8'd0;
            ovr_q   <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fi_q    <= fi_d;
            csum_q  <= csum_d;
            txd_q   <= txd_d;
            ovr_q   <= ovr_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // The byte is presented in the same cycle as tx_start, then held.
    assign tx_data     = (state_q == ST_LOAD) ? cur_byte : txd_q;
    assign busy        = (state_q != ST_IDLE);
    assign overrun     = ovr_q;
    assign frame_count = fcnt_q;

endmodule
